// File: rtl/intpol2_stream.sv
// Streaming 2nd-order (quadratic) interpolator: every three-sample window
// m0, m1, m2 produces L = 2^k output samples y(0)..y(L-1) starting at m0.
// Each output is saturated to DATA_WIDTH bits, and any saturation sets a
// sticky flag.
module intpol2_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_LMAX  = 6
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               clear,
    input  logic [$clog2(LOG2_LMAX+1)-1:0]     log2_l,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [DATA_WIDTH-1:0]              s_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic                               busy,
    output logic                               sat_flag
);

    localparam int KW = $clog2(LOG2_LMAX + 1);
    localparam int IW = (LOG2_LMAX > 0) ? LOG2_LMAX : 1;
    // Wide enough for 2*m0*2^(2k) + P1*i*2^k + P2*i^2 at the largest k.
    localparam int W  = DATA_WIDTH + 2 * LOG2_LMAX + 4;

    localparam logic signed [W-1:0] Y_MAX = {{(W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] Y_MIN = {{(W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {FILL, RUN, ADVANCE} state_t;

    state_t                        state, state_n;
    logic [1:0]                    fill_cnt;
    logic [IW-1:0]                 idx;
    logic [KW-1:0]                 k_lat;
    logic [KW-1:0]                 k_next;
    logic                          rst_done;
    logic signed [DATA_WIDTH-1:0]  m0, m1, m2;

    logic                          s_fire;
    logic                          out_free;
    logic                          load;
    logic                          i_last;
    logic                          fill_done;

    logic signed [W-1:0]           m0_w, m1_w, m2_w, i_w;
    logic signed [W-1:0]           p1, p2, acc, y_full;
    logic [KW:0]                   sh;
    logic                          y_sat;
    logic [DATA_WIDTH-1:0]         y_out;

    // Handshake strobes come from registered state only, so m_ready never
    // reaches s_ready or busy combinationally.
    assign s_ready   = rst_done && (state != RUN);
    assign busy      = (state != FILL);
    assign s_fire    = s_valid && s_ready;
    assign out_free  = !m_valid || m_ready;
    assign load      = (state == RUN) && out_free;
    assign fill_done = (state == FILL) && s_fire && (fill_cnt == 2'd2);
    assign i_last    = (({1'b0, idx} + (IW+1)'(1)) == ((IW+1)'(1) << k_lat));
    assign k_next    = (log2_l > KW'(LOG2_LMAX)) ? KW'(LOG2_LMAX) : log2_l;

    // Quadratic evaluation of the current window at index i, then saturation.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        m0_w   = W'(m0);
        m1_w   = W'(m1);
        m2_w   = W'(m2);
        i_w    = W'(idx);
        sh     = {k_lat, 1'b1};
        p1     = (m1_w <<< 2) - (m0_w <<< 1) - m0_w - m2_w;
        p2     = m0_w + m2_w - (m1_w <<< 1);
        acc    = (m0_w <<< sh) + ((p1 * i_w) <<< k_lat) + (p2 * i_w * i_w);
        y_full = acc >>> sh;
        y_sat  = 1'b0;
        y_out  = y_full[DATA_WIDTH-1:0];
        if (y_full > Y_MAX) begin
            y_sat = 1'b1;
            y_out = Y_MAX[DATA_WIDTH-1:0];
        end else if (y_full < Y_MIN) begin
            y_sat = 1'b1;
            y_out = Y_MIN[DATA_WIDTH-1:0];
        end
    end

    // Next-state decode; clear wins over every handshake.
    always_comb begin
        state_n = state;
        unique case (state)
            FILL:    if (fill_done)        state_n = RUN;
            RUN:     if (load && i_last)   state_n = ADVANCE;
            ADVANCE: if (s_fire)           state_n = RUN;
            default:                       state_n = FILL;
        endcase
        if (clear) state_n = FILL;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state always uses non-blocking assignments to avoid ordering races.
        if (!rstn) state <= FILL;
        else       state <= state_n;
    end

    // Holds s_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_done <= 1'b0;
        else       rst_done <= 1'b1;
    end

    // Window, index, latched factor, output register and sticky saturation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_cnt <= '0;
            idx      <= '0;
            k_lat    <= '0;
            m0       <= '0;
            m1       <= '0;
            m2       <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            sat_flag <= 1'b0;
        end else if (clear) begin
            // Window and k are refilled/relatched before use, so they are left alone.
            fill_cnt <= '0;
            idx      <= '0;
            m_valid  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (s_fire) begin
                m0 <= m1;
                m1 <= m2;
                m2 <= $signed(s_data);
                if (state == FILL) begin
                    fill_cnt <= fill_done ? 2'd0 : fill_cnt + 2'd1;
                    if (fill_done) begin
                        k_lat <= k_next;
                        idx   <= '0;
                    end
                end else begin
                    idx <= '0;
                end
            end
            if (load) begin
                m_data  <= y_out;
                m_valid <= 1'b1;
                idx     <= idx + IW'(1);
                if (y_sat) sat_flag <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_intpol2_stream.sv
// Bench for intpol2_stream: directed vectors plus randomized windows, all
// scored against a reference model that evaluates the interpolation
// polynomial with plain integer arithmetic.
module tb_intpol2_stream;

    localparam int DW   = 16;
    localparam int LMAX = 6;
    localparam int KW   = $clog2(LMAX + 1);

    logic          clk = 1'b0;
    logic          rstn, clear, s_valid, s_ready, m_valid, m_ready, busy, sat_flag;
    logic [KW-1:0] log2_l;
    logic [DW-1:0] s_data, m_data;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    longint exp_q[$];
    longint got_q[$];
    int     cyc_q[$];
    int     nsamp    = 0;
    longint w0 = 0, w1 = 0, w2 = 0;
    int     k_lat    = 0;
    bit     exp_sat  = 0;
    bit     rand_ready = 0;
    logic   prev_v = 1'b0, prev_r = 1'b0, prev_c = 1'b0;
    logic [DW-1:0] prev_d = '0;

    intpol2_stream #(.DATA_WIDTH(DW), .LOG2_LMAX(LMAX)) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .log2_l(log2_l),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    // y(i) of the window (a,b,c) with L = 2^k, exact rational floor.
    function automatic longint ref_y(input longint a, input longint b, input longint c,
                                     input int k, input longint i);
        longint l, p1, p2, num;
        l   = longint'(1) << k;
        p1  = 4 * b - 3 * a - c;
        p2  = a + c - 2 * b;
        num = 2 * a * l * l + p1 * i * l + p2 * i * i;
        return floor_div(num, 2 * l * l);
    endfunction

    task automatic model_accept(input longint d);
        longint y;
        w0 = w1; w1 = w2; w2 = d;
        nsamp++;
        if (nsamp == 3) k_lat = (int'(log2_l) > LMAX) ? LMAX : int'(log2_l);
        if (nsamp >= 3) begin
            for (int i = 0; i < (1 << k_lat); i++) begin
                y = ref_y(w0, w1, w2, k_lat, i);
                if (y > 32767)       begin y = 32767;  exp_sat = 1; end
                else if (y < -32768) begin y = -32768; exp_sat = 1; end
                exp_q.push_back(y);
            end
        end
    endtask

    // Monitor and scoreboard: compares every accepted output, checks that a
    // stalled output holds, and feeds the model with every accepted sample.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            nsamp   = 0;
            exp_sat = 0;
            prev_v  = 1'b0;
        end else begin
            if (prev_v && !prev_r && !prev_c) begin
                check("hold_m_valid", m_valid, 1);
                check("hold_m_data", $signed(m_data), $signed(prev_d));
            end
            if (m_valid && m_ready) begin
                got_q.push_back($signed(m_data));
                cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0d, expected no output", $signed(m_data));
                end else begin
                    check("m_data", $signed(m_data), exp_q.pop_front());
                end
            end
            if (clear) begin
                exp_q.delete();
                nsamp   = 0;
                exp_sat = 0;
            end else if (s_valid && s_ready) begin
                model_accept($signed(s_data));
            end
            prev_v = m_valid;
            prev_r = m_ready;
            prev_c = clear;
            prev_d = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input longint d);
        int  n;
        bit  ok;
        n = 0;
        s_valid = 1'b1;
        s_data  = d[DW-1:0];
        forever begin
            @(negedge clk);
            ok = s_ready;
            tick();
            n++;
            if (ok) break;
            if (n > 1000) begin
                check("send_timeout", n, 0);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_complete", exp_q.size(), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_got(input string name, input int base, input longint v[$]);
        check({name, "_count"}, got_q.size() - base, v.size());
        if (got_q.size() - base == v.size())
            foreach (v[i]) check(name, got_q[base + i], v[i]);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        check("wait_m_valid", m_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            base;
        int            n;
        longint        v[$];
        logic [DW-1:0] hold_d;
        longint        d;

        rstn = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0;
        m_ready = 1'b0; log2_l = 3'd2;

        // Reset values while asserted and release behaviour.
        #12;
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_sat_flag", sat_flag, 0);
        #10 rstn = 1'b1;
        #1;
        check("s_ready_before_edge", s_ready, 0);
        @(posedge clk); #1;
        check("s_ready_after_release", s_ready, 1);
        check("busy_after_release", busy, 0);

        // L=4 squares: two windows back to back with a one-cycle gap.
        m_ready = 1'b1;
        base = got_q.size();
        send(0); send(16); send(64); send(144);
        drain();
        v = '{0, 1, 4, 9, 16, 25, 36, 49};
        check_got("l4_squares", base, v);
        if (cyc_q.size() >= base + 8) begin
            check("window_burst", cyc_q[base + 3] - cyc_q[base], 3);
            check("window_gap", cyc_q[base + 4] - cyc_q[base + 3], 2);
        end
        check("busy_in_advance", busy, 1);
        check("l4_sat_flag", sat_flag, 0);

        // L=2 linear ramp.
        do_clear();
        check("busy_after_clear", busy, 0);
        log2_l = 3'd1;
        base = got_q.size();
        send(100); send(200); send(300);
        drain();
        v = '{100, 150};
        check_got("l2_ramp", base, v);
        check("l2_sat_flag", sat_flag, 0);

        // Positive saturation, sticky until clear.
        do_clear();
        log2_l = 3'd2;
        base = got_q.size();
        send(32767); send(32767); send(-32768);
        drain();
        v = '{32767, 32767, 32767, 32767};
        check_got("sat_window", base, v);
        check("sat_flag_set", sat_flag, 1);
        repeat (5) tick();
        check("sat_flag_sticky", sat_flag, 1);
        do_clear();
        check("sat_flag_cleared", sat_flag, 0);

        // Output stall for five cycles during RUN.
        log2_l = 3'd2;
        m_ready = 1'b0;
        base = got_q.size();
        send(0); send(16); send(64);
        wait_valid();
        hold_d = m_data;
        repeat (5) begin
            tick();
            check("stall_m_valid", m_valid, 1);
            check("stall_m_data", m_data, hold_d);
        end
        m_ready = 1'b1;
        drain();
        v = '{0, 1, 4, 9};
        check_got("stall_resume", base, v);

        // log2_l changes during RUN do not affect the latched factor.
        do_clear();
        log2_l = 3'd2;
        base = got_q.size();
        send(0); send(16); send(64);
        tick();
        log2_l = 3'd3;
        send(144);
        drain();
        v = '{0, 1, 4, 9, 16, 25, 36, 49};
        check_got("l_kept_during_run", base, v);
        do_clear();
        base = got_q.size();
        send(0); send(16); send(64);
        drain();
        v = '{0, 0, 1, 2, 4, 6, 9, 12};
        check_got("l8_after_refill", base, v);
        do_clear();
        log2_l = 3'd7;
        base = got_q.size();
        send(0); send(16); send(64);
        drain();
        check("l_clamped_count", got_q.size() - base, 64);
        if (got_q.size() - base == 64) check("l_clamped_last", got_q[base + 63], 15);

        // Asynchronous reset in the middle of RUN discards the window.
        do_clear();
        log2_l = 3'd2;
        m_ready = 1'b0;
        send(100); send(200); send(300);
        wait_valid();
        #2 rstn = 1'b0;
        #1;
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_s_ready", s_ready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_m_data", m_data, 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        m_ready = 1'b1;
        tick();
        base = got_q.size();
        send(7); send(8);
        n = 0;
        repeat (4) begin
            tick();
            if (m_valid) n++;
        end
        check("no_output_before_third", n, 0);
        send(9);
        drain();
        check("post_reset_count", got_q.size() - base, 4);
        if (got_q.size() > base) check("post_reset_first", got_q[base], 7);

        // Randomized windows with random back-pressure and random L.
        rand_ready = 1;
        for (int r = 0; r < 8; r++) begin
            do_clear();
            log2_l = (r == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            n = $urandom_range(3, 8);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) tick();
                if (r % 2 == 1) d = longint'($urandom_range(0, 65535)) - 32768;
                else            d = longint'($urandom_range(0, 2000)) - 1000;
                send(d);
            end
            drain();
            check("rand_sat_flag", sat_flag, exp_sat);
        end
        rand_ready = 0;
        m_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
